// File: rtl/add_sub_bist.sv
// add_sub_bist: exhaustive self-test driver/checker for a WIDTH-bit
// adder/subtractor. Walks every {m, b, a} combination (all adds first, then all
// subtracts), drives the operands, waits SETTLE_CYCLES, samples s_i/v_i once
// per vector and compares against an internal golden model.
//
// Optional build macro: ADDSUB_BIST_FIRST_FAIL_EN
//   defined   - fail_vec/fail_valid capture the first failing {m, b, a} of a run
//   undefined - fail_vec/fail_valid are tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begins a full run when sampled high in IDLE or DONE
//   a_o, b_o   out  operands to the adder/subtractor
//   m_o        out  mode: 0 = add, 1 = subtract
//   s_i, v_i   in   sum/difference and signed-overflow flag from the DUT
//   busy       out  run in progress
//   done       out  run finished (held until next start)
//   pass       out  valid with done: no mismatches seen
//   err_count  out  saturating mismatch count
//   fail_vec   out  first failing vector {m, b, a}
//   fail_valid out  fail_vec holds a capture
`timescale 1ns/1ps

module add_sub_bist #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 m_o,
    input  logic [WIDTH-1:0]     s_i,
    input  logic                 v_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     fail_vec,
    output logic                 fail_valid
);

    localparam int VW    = 2*WIDTH + 1;
    localparam int EW    = 2*WIDTH + 2;
    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    // Golden model: returns {v, s}. Overflow is the carry into the MSB XOR the
    // carry out of the MSB.
    function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             m);
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] low;
        bx   = b ^ {WIDTH{m}};
        full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, m};
        low  = {1'b0, a[WIDTH-2:0]} + {1'b0, bx[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, m};
        return {low[WIDTH-1] ^ full[WIDTH], full[WIDTH-1:0]};
    endfunction

    state_t           state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [EW-1:0]    err_q, err_d;
    logic [WIDTH:0]   gold;
    logic             mismatch;

    assign gold = golden(a_q, b_q, m_q);

`ifdef ADDSUB_BIST_FIRST_FAIL_EN
    logic [VW-1:0] fail_vec_q, fail_vec_d;
    logic          fail_valid_q, fail_valid_d;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        mismatch = 1'b0;
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // A start in DONE is a full restart; operands keep their values
                // until the first APPLY.
                if (start) begin
                    err_d   = '0;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_APPLY;
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
`endif
                end
            end
            S_APPLY: begin
                a_d     = vec_q[WIDTH-1:0];
                b_d     = vec_q[2*WIDTH-1:WIDTH];
                m_d     = vec_q[2*WIDTH];
                cnt_d   = SETTLE_INIT;
                state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                mismatch = ({v_i, s_i} != gold);
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + 1'b1;
                end
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
                if (mismatch && !fail_valid_q) begin
                    fail_vec_d   = {m_q, b_q, a_q};
                    fail_valid_d = 1'b1;
                end
`endif
                if (vec_q == '1) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
`endif
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign m_o       = m_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef ADDSUB_BIST_FIRST_FAIL_EN
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`else
    assign fail_vec   = '0;
    assign fail_valid = 1'b0;
`endif

endmodule
